// File: rtl/motor_drive.sv
// Two-channel H-bridge driver: decodes the steering command into per-wheel duty
// and sense, ramps duty, sequences polarity reversals through a dead time, and emits PWM.
module motor_drive #(
  parameter int unsigned PWM_PERIOD    = 5000,
  parameter int unsigned DUTY_FULL     = 4000,
  parameter int unsigned DUTY_VEER     = 2500,
  parameter int unsigned DUTY_HARD     = 1000,
  parameter int unsigned RAMP_STEP     = 50,
  parameter int unsigned RAMP_INTERVAL = 5000,
  parameter int unsigned DEAD_TIME     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] DIR,
  input  logic       Direction,
  output logic       LPWM,
  output logic       RPWM,
  output logic [1:0] LIN,
  output logic [1:0] RIN,
  output logic       Settled
);

  localparam logic [15:0] FULL     = 16'(DUTY_FULL);
  localparam logic [15:0] VEER     = 16'(DUTY_VEER);
  localparam logic [15:0] HARD     = 16'(DUTY_HARD);
  localparam logic [15:0] STEP     = 16'(RAMP_STEP);
  localparam logic [15:0] TICK_MAX = 16'(RAMP_INTERVAL - 1);
  localparam logic [15:0] PWM_MAX  = 16'(PWM_PERIOD - 1);
  localparam logic [15:0] DEAD_MAX = 16'(DEAD_TIME - 1);

  typedef enum logic [1:0] {RUN, RAMP_DOWN, DEAD} wheel_state_e;

  // Index 0 is the left wheel, index 1 the right wheel.
  wheel_state_e     state_q [2];
  wheel_state_e     state_d [2];
  logic [1:0][15:0] duty_q, duty_d;
  logic [1:0][15:0] cmp_q, cmp_d;
  logic [1:0][15:0] dead_cnt_q, dead_cnt_d;
  logic [1:0]       pol_q, pol_d;        // 1 = forward
  logic [1:0][1:0]  in_q, in_d;
  logic [1:0]       pwm_q, pwm_d;
  logic [15:0]      tick_cnt_q, tick_cnt_d;
  logic [15:0]      pwm_cnt_q, pwm_cnt_d;
  logic             settled_q, settled_d;

  logic [1:0][15:0] target;
  logic [1:0][15:0] eff;
  logic [1:0][15:0] diff;
  logic [1:0][15:0] delta;
  logic [1:0]       raw_fwd;
  logic [1:0]       cmd_fwd;
  logic [1:0]       rev_req;
  logic             sense_valid;
  logic             tick;

  // Command decode. Unlisted codes stop both wheels and leave the sense alone.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    target      = '0;
    raw_fwd     = 2'b11;
    sense_valid = 1'b0;
    unique case (DIR)
      4'b0000: begin target = {FULL, FULL}; sense_valid = 1'b1; end
      4'b1001: begin target = {VEER, FULL}; sense_valid = 1'b1; end
      4'b1010: begin target = {HARD, FULL}; sense_valid = 1'b1; end
      4'b1011: begin target = {FULL, FULL}; raw_fwd = 2'b01; sense_valid = 1'b1; end
      4'b0101: begin target = {FULL, VEER}; sense_valid = 1'b1; end
      4'b0110: begin target = {FULL, HARD}; sense_valid = 1'b1; end
      4'b0111: begin target = {FULL, FULL}; raw_fwd = 2'b10; sense_valid = 1'b1; end
      default: ;
    endcase
    cmd_fwd = sense_valid ? (raw_fwd ~^ {2{Direction}}) : pol_q;
  end

  assign tick = (tick_cnt_q == TICK_MAX);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 16'd1;
    pwm_cnt_d  = (pwm_cnt_q == PWM_MAX) ? '0 : pwm_cnt_q + 16'd1;
    rev_req    = '0;
    eff        = '0;
    diff       = '0;
    delta      = '0;
    duty_d     = duty_q;
    dead_cnt_d = dead_cnt_q;
    pol_d      = pol_q;
    in_d       = in_q;
    cmp_d      = cmp_q;
    pwm_d      = '0;
    for (int w = 0; w < 2; w++) begin
      state_d[w] = state_q[w];
      rev_req[w] = (cmd_fwd[w] != pol_q[w]) && (target[w] != '0);
      eff[w]     = target[w];
      unique case (state_q[w])
        RUN: begin
          if (rev_req[w]) begin
            eff[w]        = '0;
            dead_cnt_d[w] = '0;
            state_d[w]    = (duty_q[w] == '0) ? DEAD : RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          eff[w] = '0;
          if (cmd_fwd[w] == pol_q[w]) begin
            state_d[w] = RUN;
          end else if (duty_q[w] == '0) begin
            dead_cnt_d[w] = '0;
            state_d[w]    = DEAD;
          end
        end
        DEAD: begin
          // Dead time always runs to completion regardless of the command.
          eff[w] = '0;
          if (dead_cnt_q[w] == DEAD_MAX) begin
            pol_d[w]   = ~pol_q[w];
            state_d[w] = RUN;
          end else begin
            dead_cnt_d[w] = dead_cnt_q[w] + 16'd1;
          end
        end
        default: state_d[w] = RUN;
      endcase

      diff[w]  = (duty_q[w] < eff[w]) ? eff[w] - duty_q[w] : duty_q[w] - eff[w];
      delta[w] = (diff[w] > STEP) ? STEP : diff[w];
      if (tick) begin
        duty_d[w] = (duty_q[w] < eff[w]) ? duty_q[w] + delta[w] : duty_q[w] - delta[w];
      end

      in_d[w]  = (state_d[w] == DEAD) ? 2'b00 : (pol_d[w] ? 2'b10 : 2'b01);
      cmp_d[w] = (pwm_cnt_q == '0) ? duty_q[w] : cmp_q[w];
      pwm_d[w] = (pwm_cnt_q < cmp_d[w]);
    end
    settled_d = (state_q[0] == RUN) && (state_q[1] == RUN) &&
                (duty_q[0] == target[0]) && (duty_q[1] == target[1]);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      for (int w = 0; w < 2; w++) state_q[w] <= RUN;
      duty_q     <= '0;
      cmp_q      <= '0;
      dead_cnt_q <= '0;
      pol_q      <= 2'b11;
      in_q       <= {2'b10, 2'b10};
      pwm_q      <= '0;
      tick_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      settled_q  <= 1'b0;
    end else begin
      for (int w = 0; w < 2; w++) state_q[w] <= state_d[w];
      duty_q     <= duty_d;
      cmp_q      <= cmp_d;
      dead_cnt_q <= dead_cnt_d;
      pol_q      <= pol_d;
      in_q       <= in_d;
      pwm_q      <= pwm_d;
      tick_cnt_q <= tick_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      settled_q  <= settled_d;
    end
  end

  assign LPWM    = pwm_q[0];
  assign RPWM    = pwm_q[1];
  assign LIN     = in_q[0];
  assign RIN     = in_q[1];
  assign Settled = settled_q;

endmodule

// File: tb/tb_motor_drive.sv
// Bench for motor_drive: directed scenarios plus random command sequences, all
// compared every cycle against a behavioural wheel model built from the command table.
module tb_motor_drive;

  localparam int PP   = 100;
  localparam int FULL = 80;
  localparam int VEER = 50;
  localparam int HARD = 20;
  localparam int STEP = 10;
  localparam int RI   = 4;
  localparam int DT   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dir;
  logic       direction;
  logic       LPWM, RPWM, Settled;
  logic [1:0] LIN, RIN;

  int n_checks = 0;
  int n_errors = 0;

  // Model: per wheel a polarity, a duty, a "reversing" flag and a dead-time countdown.
  int m_tcnt, m_pcnt;
  int m_duty [2];
  int m_cmp  [2];
  int m_dead [2];
  bit m_pol  [2];
  bit m_rev  [2];
  bit m_pwm  [2];
  bit m_settled;

  motor_drive #(
    .PWM_PERIOD(PP), .DUTY_FULL(FULL), .DUTY_VEER(VEER), .DUTY_HARD(HARD),
    .RAMP_STEP(STEP), .RAMP_INTERVAL(RI), .DEAD_TIME(DT)
  ) dut (
    .clk(clk), .rst(rst), .DIR(dir), .Direction(direction),
    .LPWM(LPWM), .RPWM(RPWM), .LIN(LIN), .RIN(RIN), .Settled(Settled)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sense: 1 forward, 0 reverse, -1 keep current polarity.
  function automatic void decode(input logic [3:0] d, output int tl, output int tr,
                                 output int sl, output int sr);
    case (d)
      4'b0000: begin tl = FULL; tr = FULL; sl = 1;  sr = 1;  end
      4'b1001: begin tl = FULL; tr = VEER; sl = 1;  sr = 1;  end
      4'b1010: begin tl = FULL; tr = HARD; sl = 1;  sr = 1;  end
      4'b1011: begin tl = FULL; tr = FULL; sl = 1;  sr = 0;  end
      4'b0101: begin tl = VEER; tr = FULL; sl = 1;  sr = 1;  end
      4'b0110: begin tl = HARD; tr = FULL; sl = 1;  sr = 1;  end
      4'b0111: begin tl = FULL; tr = FULL; sl = 0;  sr = 1;  end
      default: begin tl = 0;    tr = 0;    sl = -1; sr = -1; end
    endcase
  endfunction

  function automatic logic [1:0] exp_in(input int w);
    if (m_dead[w] > 0) return 2'b00;
    return m_pol[w] ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    m_tcnt = 0; m_pcnt = 0; m_settled = 0;
    for (int w = 0; w < 2; w++) begin
      m_duty[w] = 0; m_cmp[w] = 0; m_dead[w] = 0;
      m_pol[w] = 1; m_rev[w] = 0; m_pwm[w] = 0;
    end
  endtask

  // One clock: predict from pre-edge inputs, commit at the edge, compare all outputs.
  task automatic step();
    int tg[2]; int sn[2]; int nduty[2]; int ncmp[2]; int ndead[2];
    bit npol[2]; bit nrev[2]; bit npwm[2]; bit nset; bit tick; bit want; int eff;
    decode(dir, tg[0], tg[1], sn[0], sn[1]);
    tick = (m_tcnt == RI - 1);
    nset = 1;
    for (int w = 0; w < 2; w++) begin
      if (sn[w] >= 0 && !direction) sn[w] = 1 - sn[w];
      ncmp[w] = (m_pcnt == 0) ? m_duty[w] : m_cmp[w];
      npwm[w] = (m_pcnt < ncmp[w]);
      if (m_dead[w] > 0 || m_rev[w] || m_duty[w] != tg[w]) nset = 0;
      want = (sn[w] >= 0) && (sn[w] != int'(m_pol[w]));
      nduty[w] = m_duty[w]; npol[w] = m_pol[w]; nrev[w] = m_rev[w]; ndead[w] = m_dead[w];
      eff = tg[w];
      if (m_dead[w] > 0) begin
        eff = 0;
        ndead[w] = m_dead[w] - 1;
        if (ndead[w] == 0) npol[w] = !m_pol[w];
      end else if (m_rev[w]) begin
        eff = 0;
        if (!want) nrev[w] = 0;
        else if (m_duty[w] == 0) begin nrev[w] = 0; ndead[w] = DT; end
      end else if (want && tg[w] > 0) begin
        eff = 0;
        if (m_duty[w] > 0) nrev[w] = 1;
        else ndead[w] = DT;
      end
      if (tick) begin
        if (m_duty[w] < eff) nduty[w] = m_duty[w] + ((eff - m_duty[w] > STEP) ? STEP : eff - m_duty[w]);
        else nduty[w] = m_duty[w] - ((m_duty[w] - eff > STEP) ? STEP : m_duty[w] - eff);
      end
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_tcnt = tick ? 0 : m_tcnt + 1;
      m_pcnt = (m_pcnt == PP - 1) ? 0 : m_pcnt + 1;
      m_settled = nset;
      for (int w = 0; w < 2; w++) begin
        m_duty[w] = nduty[w]; m_cmp[w] = ncmp[w]; m_dead[w] = ndead[w];
        m_pol[w] = npol[w]; m_rev[w] = nrev[w]; m_pwm[w] = npwm[w];
      end
    end
    #1;
    check("lpwm", 32'(LPWM), 32'(m_pwm[0]));
    check("rpwm", 32'(RPWM), 32'(m_pwm[1]));
    check("lin", 32'(LIN), 32'(exp_in(0)));
    check("rin", 32'(RIN), 32'(exp_in(1)));
    check("settled", 32'(Settled), 32'(m_settled));
  endtask

  task automatic wait_settled(input string tag, input int budget);
    bit ok = 0;
    step(); step();
    for (int i = 0; i < budget; i++) begin
      if (Settled === 1'b1) begin ok = 1; break; end
      step();
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic count_high(input int n, output int l, output int r);
    l = 0; r = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (LPWM === 1'b1) l++;
      if (RPWM === 1'b1) r++;
    end
  endtask

  initial begin
    int cnt, l_hi, r_hi, dead_cyc, flips, bad, both00, one00;
    bit done;
    logic [1:0] prev;
    logic [3:0] codes [10];
    codes = '{4'b0000, 4'b1001, 4'b1010, 4'b1011, 4'b0101,
              4'b0110, 4'b0111, 4'b1111, 4'b0100, 4'b0011};
    model_reset();
    rst = 1'b1; dir = 4'b0000; direction = 1'b1;
    step(); step();
    check("reset_lin", 32'(LIN), 32'(2'b10));
    check("reset_rin", 32'(RIN), 32'(2'b10));
    check("reset_settled", 32'(Settled), 32'd0);

    // Ramp from reset to full speed: 8 ticks then one cycle for Settled.
    rst = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (Settled === 1'b1) begin cnt = i; break; end
    end
    check("ramp_settle_cycles", 32'(cnt), 32'((FULL / STEP) * RI + 1));
    step(); step(); step(); step();
    count_high(PP, l_hi, r_hi);
    count_high(PP, l_hi, r_hi);
    check("proceed_lpwm_high", 32'(l_hi), 32'(FULL));
    check("proceed_rpwm_high", 32'(r_hi), 32'(FULL));
    check("proceed_lin", 32'(LIN), 32'(2'b10));

    // HARD_RIGHT: right slows to HARD, polarity untouched.
    dir = 4'b1010;
    bad = 0;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (LIN !== 2'b10 || RIN !== 2'b10) bad++;
      if (i > 2 && Settled === 1'b1) begin done = 1; break; end
    end
    check("hard_settled", 32'(done), 32'd1);
    check("hard_pins_stable", 32'(bad), 32'd0);
    count_high(PP, l_hi, r_hi);
    count_high(PP, l_hi, r_hi);
    check("hard_lpwm_high", 32'(l_hi), 32'(FULL));
    check("hard_rpwm_high", 32'(r_hi), 32'(HARD));

    // NINETY_RIGHT from settled PROCEED: right reverses through dead time.
    dir = 4'b0000;
    wait_settled("proceed_again", 200);
    dir = 4'b1011;
    prev = RIN; dead_cyc = 0; flips = 0; bad = 0; cnt = 0; done = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (RIN === 2'b01 && Settled === 1'b1) begin done = 1; break; end
      if (RIN === 2'b00) dead_cyc++;
      if ((prev == 2'b10 && RIN == 2'b01) || (prev == 2'b01 && RIN == 2'b10)) flips++;
      if (LIN !== 2'b10) bad++;
      if (i >= 2 && Settled === 1'b1) cnt++;
      prev = RIN;
    end
    check("rev_done", 32'(done), 32'd1);
    check("rev_dead_len", 32'(dead_cyc), 32'(DT));
    check("rev_direct_flip", 32'(flips), 32'd0);
    check("rev_lin_stable", 32'(bad), 32'd0);
    check("rev_settled_low", 32'(cnt), 32'd0);

    // Abort a reversal at duty 40 during ramp-down.
    dir = 4'b0000;
    wait_settled("back_to_proceed", 400);
    dir = 4'b1011;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (m_rev[1] && m_duty[1] == 40) begin done = 1; break; end
    end
    check("abort_reached_40", 32'(done), 32'd1);
    dir = 4'b0000;
    bad = 0; done = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (RIN !== 2'b10) bad++;
      if (i > 2 && Settled === 1'b1) begin done = 1; break; end
    end
    check("abort_settled", 32'(done), 32'd1);
    check("abort_rin_held", 32'(bad), 32'd0);

    // Reset in the middle of dead time.
    dir = 4'b1011;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (m_dead[1] > 0) begin done = 1; break; end
    end
    check("dead_reached", 32'(done), 32'd1);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; dir = 4'b1111;
    check("mid_dead_lpwm", 32'(LPWM), 32'd0);
    check("mid_dead_rpwm", 32'(RPWM), 32'd0);
    check("mid_dead_lin", 32'(LIN), 32'(2'b10));
    check("mid_dead_rin", 32'(RIN), 32'(2'b10));
    check("mid_dead_settled", 32'(Settled), 32'd0);
    count_high(150, l_hi, r_hi);
    check("stop_pwm_high", 32'(l_hi + r_hi), 32'd0);

    // Direction flip: both wheels reverse together.
    dir = 4'b0000; direction = 1'b1;
    wait_settled("fwd_settled", 200);
    direction = 1'b0;
    both00 = 0; one00 = 0; done = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (i > 2 && LIN === 2'b01 && RIN === 2'b01 && Settled === 1'b1) begin done = 1; break; end
      if (LIN === 2'b00 && RIN === 2'b00) both00++;
      else if (LIN === 2'b00 || RIN === 2'b00) one00++;
    end
    check("backward_done", 32'(done), 32'd1);
    check("backward_dead_both", 32'(both00), 32'(DT));
    check("backward_dead_one", 32'(one00), 32'd0);

    // Illegal code stops both wheels without touching polarity.
    dir = 4'b0100;
    bad = 0;
    for (int i = 0; i < 140; i++) begin
      step();
      if (LIN !== 2'b01 || RIN !== 2'b01) bad++;
    end
    count_high(PP, l_hi, r_hi);
    check("illegal_pol_held", 32'(bad), 32'd0);
    check("illegal_pwm_high", 32'(l_hi + r_hi), 32'd0);

    // Random command sequences against the model.
    for (int s = 0; s < 40; s++) begin
      dir = codes[$urandom_range(9, 0)];
      direction = 1'($urandom_range(1, 0));
      rst = ($urandom_range(15, 0) == 0);
      step();
      rst = 1'b0;
      for (int i = 0; i < int'($urandom_range(80, 1)); i++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
